serial_word_deframer: RTL and testbench
=======================================

Name: serial_word_deframer

Overview:
- Receive-side counterpart to the team's free-running serial shift path: collects an LSB-first (or MSB-first) serial bit stream, qualified by a bit strobe and a frame-start marker, into N-bit words.
- Presents each completed word on a double-buffered parallel output with a valid/ready handshake.
- Flags overruns when the consumer stalls.
- Sits between a serial link or bit-level shifter and a word-oriented consumer, such as a FIFO or MMIO register.

Parameters:
- N, 8, word width in bits (N >= 2).
- LSB_FIRST, 1, 1: first received bit lands in dout[0]; 0: first received bit lands in dout[N-1].

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- s_in  input  1  serial data bit, sampled only when s_en=1.
- s_en  input  1  bit strobe; one bit is consumed per clk cycle in which s_en=1.
- s_start  input  1  frame-start marker; qualifies the current bit as bit 0 of a new word (ignored when s_en=0).
- dout  output  N  completed word; stable while dout_valid=1.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid and dout_ready are both 1.
- busy  output  1  a word is partially received (state SHIFT).
- overrun  output  1  one-cycle pulse: a completed word was dropped.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, bit count=0, shift reg=0, dout=0, dout_valid=0, busy=0, overrun=0. Reset mid-frame discards the partial word and any held word.
- FSM states: IDLE and SHIFT. busy=1 exactly in SHIFT.
- IDLE:
  - s_en=1 and s_start=1: shift in s_in, count=1, go to SHIFT.
  - s_en=1 and s_start=0: bit ignored.
  - s_en=0: hold.
- SHIFT:
  - s_en=0: hold everything.
  - s_en=1 and s_start=1: resync. Discard the partial word, shift in s_in as new bit 0, count=1, stay in SHIFT.
  - s_en=1, s_start=0, count<N-1: shift in, count+1.
  - s_en=1, s_start=0, count=N-1: word complete. The completed word is the shifted value including this bit; go to IDLE, count=0.
- Shift rule:
  - LSB_FIRST=1: next = {s_in, sr[N-1:1]}.
  - LSB_FIRST=0: next = {sr[N-2:0], s_in}.
- Word completion, where "slot free" means (dout_valid=0) or (dout_ready=1):
  - Slot free: dout <= completed word, dout_valid <= 1 on the next edge. Latency is exactly 1 cycle from the strobe of the last bit to dout_valid=1.
  - Slot not free: word dropped, dout unchanged, overrun=1 for exactly one cycle (next cycle).
- Handshake:
  - Once dout_valid=1, dout and dout_valid stay constant until a cycle with dout_ready=1.
  - On accept without a same-cycle completion: dout_valid <= 0, dout retains its value.
  - Accept and completion in the same cycle: new word loaded, dout_valid stays 1, no overrun.
- dout_ready is ignored while dout_valid=0.
- Frame completion while a held word awaits is legal; reception continues regardless of handshake state.
- Count width is $clog2(N). There is no wrap beyond N-1; completion always returns count to 0.

Decomposition:
- Package serial_word_deframer_pkg contains typedef enum logic {IDLE, SHIFT} deframer_state_t.
- No constants beyond the parameters.
- No sub-module. The shift stage and the output holding register share one always_ff/next-state split; the output stage is small enough to stay inline.

Test Plan:
- N=8, LSB_FIRST=1, dout_ready=1. Send 0xA5 as bits 1,0,1,0,0,1,0,1, one per cycle, s_start on the first -> dout=0xA5, dout_valid=1 for exactly 1 cycle, asserted 1 cycle after the 8th strobe; busy high for 7 cycles.
- LSB_FIRST=0. Send 0xA5 MSB-first (1,0,1,0,0,1,0,1) with gaps of 2 idle cycles between strobes -> dout=0xA5; gaps cause no state change.
- dout_ready=0. Send 0x3C then 0xC3 -> dout stays 0x3C with dout_valid=1, overrun pulses once after the 8th bit of 0xC3. Then assert dout_ready -> dout_valid falls, dout=0x3C unchanged.
- Hold 0x11 with dout_ready=0. Raise dout_ready in the same cycle as the last bit of 0x22 -> next cycle dout=0x22, dout_valid=1, no overrun.
- Send 5 bits, then s_start with 8 bits of 0x5A -> dout=0x5A. The partial word is discarded and no overrun is flagged.
- After 4 bits, pulse reset_n low asynchronously (between clk edges) -> outputs 0 immediately, state IDLE. Bits without s_start afterwards are ignored until the next s_start.

Source files
------------

// File: rtl/serial_word_deframer_pkg.sv
// Shared types for the serial word deframer: the two-state receive FSM encoding.
package serial_word_deframer_pkg;

    typedef enum logic {IDLE, SHIFT} deframer_state_t;

endpackage

// File: rtl/serial_word_deframer.sv
// Collects a strobed serial bit stream into N-bit words framed by s_start and
// presents them on a single held output word with a valid/ready handshake.
module serial_word_deframer
    import serial_word_deframer_pkg::*;
#(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_in,
    input  logic         s_en,
    input  logic         s_start,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         busy,
    output logic         overrun
);

    localparam int CNT_W = $clog2(N);

    deframer_state_t  r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [N-1:0]     r_sr, w_sr_nxt;
    logic [N-1:0]     r_dout, w_dout_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_overrun, w_overrun_nxt;
    logic [N-1:0]     w_shifted;
    logic [N-1:0]     w_first;
    logic             w_complete;
    logic             w_slot_free;

    // A new frame starts from a cleared register so stale partial bits never leak.
    generate
        if (LSB_FIRST) begin : g_lsb
            assign w_shifted = {s_in, r_sr[N-1:1]};
            assign w_first   = {s_in, {(N-1){1'b0}}};
        end else begin : g_msb
            assign w_shifted = {r_sr[N-2:0], s_in};
            assign w_first   = {{(N-1){1'b0}}, s_in};
        end
    endgenerate

    assign w_slot_free = ~r_valid | dout_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sr_nxt    = r_sr;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (s_en && s_start) begin
                    w_sr_nxt    = w_first;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (s_en) begin
                    if (s_start) begin
                        w_sr_nxt  = w_first;
                        w_cnt_nxt = CNT_W'(1);
                    end else if (r_cnt == CNT_W'(N - 1)) begin
                        w_sr_nxt    = w_shifted;
                        w_cnt_nxt   = '0;
                        w_complete  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_sr_nxt  = w_shifted;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output slot: a completion wins over a plain accept so back-to-back words stay valid.
    always_comb begin
        w_dout_nxt    = r_dout;
        w_valid_nxt   = r_valid;
        w_overrun_nxt = 1'b0;
        if (w_complete && w_slot_free) begin
            w_dout_nxt  = w_shifted;
            w_valid_nxt = 1'b1;
        end else begin
            if (w_complete) begin
                w_overrun_nxt = 1'b1;
            end
            if (r_valid && dout_ready) begin
                w_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_sr      <= '0;
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sr      <= w_sr_nxt;
            r_dout    <= w_dout_nxt;
            r_valid   <= w_valid_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign busy       = (r_state == SHIFT);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_word_deframer.sv
// Bench for serial_word_deframer: one LSB-first and one MSB-first instance share the
// same serial stream; accepted words are checked against a queue of expected words.
module tb_serial_word_deframer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_in, s_en, s_start, dout_ready;
    logic [7:0] dout_l, dout_m;
    logic       dv_l, dv_m, busy_l, busy_m, ovr_l, ovr_m;

    int n_checks = 0;
    int n_err    = 0;
    int busy_cnt = 0;
    int ovr_cnt_l = 0;
    int ovr_cnt_m = 0;
    logic [7:0] q_l[$];
    logic [7:0] q_m[$];

    always #5 clk = ~clk;

    serial_word_deframer #(.N(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset_n(reset_n), .s_in(s_in), .s_en(s_en), .s_start(s_start),
        .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
        .busy(busy_l), .overrun(ovr_l)
    );

    serial_word_deframer #(.N(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset_n(reset_n), .s_in(s_in), .s_en(s_en), .s_start(s_start),
        .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
        .busy(busy_m), .overrun(ovr_m)
    );

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer side pops on every handshake, then the clock advances.
    task automatic tick();
        if (dv_l && dout_ready) begin
            if (q_l.size() == 0) chk("lsb_unexpected_word", 32'(q_l.size()), 32'd1);
            else chk("lsb_word", {24'd0, dout_l}, {24'd0, q_l.pop_front()});
        end
        if (dv_m && dout_ready) begin
            if (q_m.size() == 0) chk("msb_unexpected_word", 32'(q_m.size()), 32'd1);
            else chk("msb_word", {24'd0, dout_m}, {24'd0, q_m.pop_front()});
        end
        @(posedge clk);
        #1;
        busy_cnt  += int'(busy_l);
        ovr_cnt_l += int'(ovr_l);
        ovr_cnt_m += int'(ovr_m);
    endtask

    // Sends d[0] first; optional idle gap after each bit except the last.
    task automatic send_bits(input logic [7:0] d, input int nbits, input int gap,
                             input bit with_start, input bit rdy_last);
        for (int i = 0; i < nbits; i++) begin
            s_en    = 1'b1;
            s_in    = d[i];
            s_start = with_start && (i == 0);
            if (rdy_last && i == nbits - 1) dout_ready = 1'b1;
            tick();
            s_en = 1'b0; s_start = 1'b0; s_in = 1'b0;
            if (i < nbits - 1) repeat (gap) tick();
        end
    endtask

    task automatic send_word(input logic [7:0] d, input int gap, input bit push, input bit rdy_last);
        if (push) begin
            q_l.push_back(d);
            q_m.push_back(rev8(d));
        end
        send_bits(d, 8, gap, 1'b1, rdy_last);
    endtask

    task automatic clear_counts();
        busy_cnt = 0; ovr_cnt_l = 0; ovr_cnt_m = 0;
    endtask

    initial begin
        reset_n = 1'b0; s_in = 1'b0; s_en = 1'b0; s_start = 1'b0; dout_ready = 1'b1;
        #2;
        chk("rst_dout", {16'd0, dout_l, dout_m}, 32'd0);
        chk("rst_valid", {30'd0, dv_l, dv_m}, 32'd0);
        chk("rst_busy_ovr", {28'd0, busy_l, busy_m, ovr_l, ovr_m}, 32'd0);
        #5 reset_n = 1'b1;
        @(posedge clk); #1;
        tick();

        // Basic LSB-first word, consumer always ready
        clear_counts();
        send_word(8'hA5, 0, 1'b1, 1'b0);
        chk("t1_valid", {30'd0, dv_l, dv_m}, 32'h3);
        chk("t1_dout_l", {24'd0, dout_l}, 32'hA5);
        chk("t1_dout_m", {24'd0, dout_m}, 32'(rev8(8'hA5)));
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd7);
        tick();
        chk("t1_valid_one_cycle", {30'd0, dv_l, dv_m}, 32'd0);
        tick();

        // Same pattern with idle gaps between strobes
        clear_counts();
        send_word(8'h5C, 2, 1'b1, 1'b0);
        chk("t2_dout_m", {24'd0, dout_m}, 32'(rev8(8'h5C)));
        chk("t2_dout_l", {24'd0, dout_l}, 32'h5C);
        chk("t2_busy_through_gaps", 32'(busy_cnt), 32'd21);
        tick();
        chk("t2_queues_empty", 32'(q_l.size() + q_m.size()), 32'd0);

        // Stalled consumer: second word dropped with a single overrun pulse
        dout_ready = 1'b0;
        clear_counts();
        send_word(8'h3C, 0, 1'b1, 1'b0);
        send_word(8'hC3, 0, 1'b0, 1'b0);
        chk("t3_overrun_pulse", {30'd0, ovr_l, ovr_m}, 32'h3);
        tick();
        chk("t3_overrun_low", {30'd0, ovr_l, ovr_m}, 32'd0);
        chk("t3_overrun_count", 32'(ovr_cnt_l + ovr_cnt_m), 32'd2);
        chk("t3_held_dout", {16'd0, dout_l, dout_m}, {16'd0, 8'h3C, rev8(8'h3C)});
        chk("t3_held_valid", {30'd0, dv_l, dv_m}, 32'h3);
        dout_ready = 1'b1;
        tick();
        chk("t3_valid_falls", {30'd0, dv_l, dv_m}, 32'd0);
        chk("t3_dout_retained", {16'd0, dout_l, dout_m}, {16'd0, 8'h3C, rev8(8'h3C)});

        // Accept coinciding with completion reloads without overrun
        dout_ready = 1'b0;
        clear_counts();
        send_word(8'h11, 0, 1'b1, 1'b0);
        send_word(8'h22, 0, 1'b1, 1'b1);
        chk("t4_dout", {16'd0, dout_l, dout_m}, {16'd0, 8'h22, rev8(8'h22)});
        chk("t4_valid", {30'd0, dv_l, dv_m}, 32'h3);
        chk("t4_no_overrun", 32'(ovr_cnt_l + ovr_cnt_m), 32'd0);
        tick();
        chk("t4_queues_empty", 32'(q_l.size() + q_m.size()), 32'd0);

        // Resync mid-word discards the partial word
        clear_counts();
        send_bits(8'h1F, 5, 0, 1'b1, 1'b0);
        chk("t5_busy_partial", {30'd0, busy_l, busy_m}, 32'h3);
        send_word(8'h5A, 0, 1'b1, 1'b0);
        chk("t5_dout", {16'd0, dout_l, dout_m}, {16'd0, 8'h5A, rev8(8'h5A)});
        tick();
        chk("t5_no_overrun", 32'(ovr_cnt_l + ovr_cnt_m), 32'd0);
        chk("t5_queues_empty", 32'(q_l.size() + q_m.size()), 32'd0);

        // Asynchronous reset mid-frame with a held word pending
        dout_ready = 1'b0;
        send_word(8'h77, 0, 1'b0, 1'b0);
        send_bits(8'h0F, 4, 0, 1'b1, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_async_dout", {16'd0, dout_l, dout_m}, 32'd0);
        chk("t6_async_flags", {26'd0, dv_l, dv_m, busy_l, busy_m, ovr_l, ovr_m}, 32'd0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b1;
        clear_counts();
        send_bits(8'hFF, 8, 0, 1'b0, 1'b0);
        tick();
        chk("t6_ignored_valid", {30'd0, dv_l, dv_m}, 32'd0);
        chk("t6_ignored_busy", 32'(busy_cnt), 32'd0);
        send_word(8'h96, 0, 1'b1, 1'b0);
        chk("t6_dout", {16'd0, dout_l, dout_m}, {16'd0, 8'h96, rev8(8'h96)});
        tick();
        tick();
        chk("t6_queues_empty", 32'(q_l.size() + q_m.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
